// File: rtl/mux_scan_ctrl.sv
// Multiplexed sensor scanner: settle, average, frame into bytes, buffer in a FIFO.
// Define SCAN_CSUM_EN to append an XOR checksum trailer byte to every frame.
module mux_scan_ctrl #(
  parameter int          NCH        = 24,
  parameter int          ADDR_W     = 5,
  parameter int          ADC_W      = 12,
  parameter int          SETTLE_CYC = 500,
  parameter int          AVG_LOG2   = 2,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont_en,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  input  logic              rd_en,
  output logic [7:0]        q,
  output logic              empty,
  output logic              full,
  output logic [15:0]       frame_cnt
);

  localparam int ACC_W   = ADC_W + AVG_LOG2;
  localparam int SCNT_W  = $clog2(SETTLE_CYC) + 1;
  localparam int NSAMP_W = AVG_LOG2 + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_CH     = ADDR_W'(NCH - 1);
  localparam logic [SCNT_W-1:0]  SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [NSAMP_W-1:0] SAMP_LAST   = NSAMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [PTR_W:0]     CNT_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SETTLE, S_ACC, S_PUSH, S_CSUM, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [NSAMP_W-1:0]   nsamp_q, nsamp_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [15:0]          frame_q, frame_d;
`ifdef SCAN_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic                 wr_en;
  logic [7:0]           wr_data;
  logic [7:0]           push_byte;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [PTR_W:0]       cnt_q, cnt_d;
  logic                 empty_q, full_q;
  logic [7:0]           q_q;
  logic                 do_rd;

  // Top byte of (acc >> AVG_LOG2) is simply the top byte of the wide accumulator.
  assign push_byte = acc_q[ACC_W-1 -: 8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      scnt_q  <= '0;
      nsamp_q <= '0;
      acc_q   <= '0;
      frame_q <= '0;
`ifdef SCAN_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      scnt_q  <= scnt_d;
      nsamp_q <= nsamp_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
`ifdef SCAN_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    scnt_d  = scnt_q;
    nsamp_d = nsamp_q;
    acc_d   = acc_q;
    frame_d = frame_q;
`ifdef SCAN_CSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start || cont_en) state_d = S_HDR;
      end
      S_HDR: begin
        if (!full_q) begin
          state_d = S_SETTLE;
          scnt_d  = '0;
`ifdef SCAN_CSUM_EN
          csum_d  = HDR_BYTE;
`endif
        end
      end
      S_SETTLE: begin
        if (scnt_q == SETTLE_LAST) begin
          state_d = S_ACC;
          acc_d   = '0;
          nsamp_d = '0;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      S_ACC: begin
        if (adc_valid) begin
          acc_d   = acc_q + ACC_W'(adc_data);
          nsamp_d = nsamp_q + NSAMP_W'(1);
          if (nsamp_q == SAMP_LAST) state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!full_q) begin
`ifdef SCAN_CSUM_EN
          csum_d = csum_q ^ push_byte;
`endif
          if (addr_q < LAST_CH) begin
            addr_d  = addr_q + ADDR_W'(1);
            scnt_d  = '0;
            state_d = S_SETTLE;
          end else begin
`ifdef SCAN_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_CSUM: begin
        if (!full_q) state_d = S_DONE;
      end
      S_DONE: begin
        frame_d = frame_q + 16'd1;
        addr_d  = '0;
        state_d = cont_en ? S_HDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
      S_HDR: begin
        wr_en   = !full_q;
        wr_data = HDR_BYTE;
      end
      S_PUSH: begin
        wr_en   = !full_q;
        wr_data = push_byte;
      end
`ifdef SCAN_CSUM_EN
      S_CSUM: begin
        wr_en   = !full_q;
        wr_data = csum_q;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign addr      = addr_q;
  assign frame_cnt = frame_q;

  assign do_rd = rd_en && !empty_q;

  always_comb begin
    unique case ({wr_en, do_rd})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
      if (do_rd) begin
        rptr_q <= rptr_q + PTR_W'(1);
        q_q    <= mem[rptr_q];
      end
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_FULL);
    end
  end

  assign q     = q_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: byte-stream scoreboard fed by a frame-level model.
module tb_mux_scan_ctrl;
  localparam int         NCH    = 4;
  localparam int         ADDR_W = 3;
  localparam int         ADC_W  = 12;
  localparam int         SETTLE = 8;
  localparam int         AVGL   = 2;
  localparam int         DEPTH  = 4;
  localparam int         NFR    = 4;
  localparam logic [7:0] HDR    = 8'hA5;

  logic              clk, reset_n, start, cont_en;
  logic [ADC_W-1:0]  adc_data;
  logic              adc_valid;
  logic [ADDR_W-1:0] addr;
  logic              busy, rd_en, empty, full;
  logic [7:0]        q;
  logic [15:0]       frame_cnt;

  logic              drv_on, k_valid, m_valid;
  logic [ADC_W-1:0]  k_data, m_data;
  int                rd_mode;
  logic [7:0]        exp_q [$];
  logic [11:0]       vals [NFR][NCH];
  int                fidx, since;
  logic [ADDR_W-1:0] last_a;
  int                errors = 0;
  int                checks = 0;

  assign adc_valid = drv_on ? k_valid : m_valid;
  assign adc_data  = drv_on ? k_data  : m_data;

  mux_scan_ctrl #(
    .NCH(NCH), .ADDR_W(ADDR_W), .ADC_W(ADC_W), .SETTLE_CYC(SETTLE),
    .AVG_LOG2(AVGL), .FIFO_DEPTH(DEPTH), .HDR_BYTE(HDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cont_en(cont_en),
    .adc_data(adc_data), .adc_valid(adc_valid), .addr(addr), .busy(busy),
    .rd_en(rd_en), .q(q), .empty(empty), .full(full), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each channel byte is the top 8 bits of the truncated mean of its samples.
  function automatic logic [7:0] avg_byte(input int sum);
    int avg;
    avg = sum / (1 << AVGL);
    return 8'(avg / (1 << (ADC_W - 8)));
  endfunction

  task automatic push_frame(input logic [7:0] b [NCH]);
    logic [7:0] x;
    x = HDR;
    exp_q.push_back(HDR);
    for (int i = 0; i < NCH; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef SCAN_CSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic drv_reset();
    fidx   = 0;
    last_a = '0;
    since  = 100;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_addr(input int ch, input string tag);
    int n = 0;
    while (addr != ADDR_W'(ch) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq(tag, addr, ch);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0 || !empty) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Reader: random/constant rd_en, checks q one cycle after an accepted read.
  initial begin
    bit pending;
    rd_en   = 1'b0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_q.size() == 0) check_eq("q_unexpected", exp_q.size(), 1);
        else check_eq("q", q, exp_q.pop_front());
      end
      case (rd_mode)
        0:       rd_en = 1'b0;
        1:       rd_en = 1'b1;
        default: rd_en = 1'($urandom_range(0, 1));
      endcase
      pending = rd_en && !empty && reset_n;
    end
  end

  // Channel-keyed sample source: holds one value per (frame, channel),
  // with 0xFFF junk strobes right after every address change.
  initial begin
    k_valid = 1'b0;
    k_data  = '0;
    forever begin
      @(negedge clk);
      k_valid = 1'b0;
      if (drv_on) begin
        if (addr != last_a) begin
          if (last_a == ADDR_W'(NCH - 1) && addr == '0) fidx++;
          since = 0;
        end else if (since < 100) begin
          since++;
        end
        last_a = addr;
        if ($urandom_range(0, 2) == 0) begin
          k_valid = 1'b1;
          k_data  = (since < 4) ? 12'hFFF : (fidx < NFR ? vals[fidx][addr] : 12'h000);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b [NCH];
    logic [11:0] seq [NCH][4];
    int          n, s;

    reset_n = 1'b0; start = 1'b0; cont_en = 1'b0;
    m_valid = 1'b0; m_data = '0; drv_on = 1'b0; rd_mode = 0;
    drv_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_q", q, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Constant 0xABC with no reader: FIFO fills, scan stalls, then drains intact.
    for (int f = 0; f < NFR; f++)
      for (int c = 0; c < NCH; c++) vals[f][c] = 12'hABC;
    for (int c = 0; c < NCH; c++) b[c] = avg_byte(4 * 'hABC);
    push_frame(b);
    drv_reset();
    drv_on = 1'b1;
    pulse_start();
    n = 0;
    while (!full && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_full", full, 1);
    repeat (60) @(negedge clk);
    check_eq("stall_addr", addr, NCH - 1);
    check_eq("stall_busy", busy, 1);
    check_eq("stall_full_hold", full, 1);
    check_eq("stall_frame_cnt", frame_cnt, 0);
    rd_mode = 1;
    wait_drain("stall_drain", 3000);
    check_eq("f1_frame_cnt", frame_cnt, 1);
    check_eq("f1_busy", busy, 0);
    check_eq("f1_addr", addr, 0);
    drv_on = 1'b0;

    // Distinct samples per channel, junk during settle, truncation and full-scale.
    seq[0] = '{12'h100, 12'h101, 12'h102, 12'h103};
    seq[1] = '{12'h200, 12'h200, 12'h200, 12'h200};
    seq[2] = '{12'h7F0, 12'h7F8, 12'h800, 12'h808};
    seq[3] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += int'(seq[c][i]);
      b[c] = avg_byte(s);
    end
    push_frame(b);
    rd_mode = 1;
    pulse_start();
    for (int c = 0; c < NCH; c++) begin
      wait_addr(c, "avg_addr_timeout");
      for (int i = 0; i < 3; i++) begin
        m_valid = 1'b1; m_data = 12'hFFF;
        @(negedge clk);
      end
      m_valid = 1'b0;
      repeat (12) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        m_valid = 1'b1; m_data = seq[c][i];
        @(negedge clk);
      end
      m_valid = 1'b0;
    end
    wait_drain("avg_drain", 3000);
    check_eq("f2_frame_cnt", frame_cnt, 2);

    // Reset while scanning channel 2.
    rd_mode = 0;
    for (int c = 0; c < NCH; c++) vals[0][c] = 12'($urandom_range(0, 4095));
    drv_reset();
    drv_on = 1'b1;
    pulse_start();
    wait_addr(2, "rst_mid_timeout");
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_addr", addr, 0);
    check_eq("rstmid_empty", empty, 1);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_frame_cnt", frame_cnt, 0);
    check_eq("rstmid_full", full, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drv_on  = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);

    // Continuous mode with random data and random reads; cont_en dropped in frame 4.
    for (int f = 0; f < NFR; f++) begin
      for (int c = 0; c < NCH; c++) begin
        vals[f][c] = 12'($urandom_range(0, 4095));
        b[c] = avg_byte(4 * int'(vals[f][c]));
      end
      push_frame(b);
    end
    drv_reset();
    drv_on  = 1'b1;
    rd_mode = 2;
    cont_en = 1'b1;
    pulse_start();
    n = 0;
    while (!(fidx == NFR - 1 && addr == ADDR_W'(2)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cont_reach_f4", fidx, NFR - 1);
    cont_en = 1'b0;
    wait_drain("cont_drain", 20000);
    check_eq("cont_frame_cnt", frame_cnt, NFR);
    check_eq("cont_busy", busy, 0);
    check_eq("cont_addr", addr, 0);
    check_eq("cont_empty", empty, 1);
    drv_on  = 1'b0;
    rd_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Parametrised successor to the fixed 3x8 sensor poller. It steps a channel address across NCH multiplexed sensor inputs and waits a programmable settle time after each switch. It then averages 2^AVG_LOG2 ADC conversions per channel and packs the results into framed bytes. The bytes go into an internal FIFO read by the UART transmitter. It sits between the serial ADC front-end and the UART transmitter; downstream logic decodes addr into the 8:1 mux selects.

Parameters:
NCH, 24, number of scanned channels (1..2^ADDR_W)
ADDR_W, 5, channel address width
ADC_W, 12, ADC sample width (>=8)
SETTLE_CYC, 500, clk cycles to wait after an address change before accepting samples (>=1)
AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
FIFO_DEPTH, 64, output FIFO depth in bytes (power of 2, >=4)
HDR_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin one frame; ignored while busy
cont_en  in  1  level: when high, start a new frame immediately after each frame ends
adc_data  in  ADC_W  conversion result, valid when adc_valid=1
adc_valid  in  1  one-cycle strobe per completed conversion
addr  out  ADDR_W  current channel index
busy  out  1  high from the start pulse until the frame completes
rd_en  in  1  FIFO read request
q  out  8  FIFO read data, registered
empty  out  1  FIFO empty
full  out  1  FIFO full
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, addr=0, busy=0, q=0, FIFO pointers=0, empty=1, full=0, frame_cnt=0, accumulator=0. Reset mid-frame discards the frame and all FIFO contents.
- FSM states are IDLE, HDR, SETTLE, ACC, PUSH, CSUM, DONE.
- IDLE: addr=0. A start pulse, or cont_en=1, moves to HDR and sets busy=1.
- HDR: writes HDR_BYTE to the FIFO when full=0, otherwise waits. Then goes to SETTLE.
- SETTLE: counts SETTLE_CYC cycles with addr stable. adc_valid is ignored. Then goes to ACC with accumulator=0 and sample count=0.
- ACC: on each adc_valid, adds adc_data into an accumulator of width ADC_W+AVG_LOG2. After 2^AVG_LOG2 strobes, goes to PUSH.
- PUSH: avg = acc >> AVG_LOG2. The byte written is avg[ADC_W-1:ADC_W-8], i.e. the top 8 bits, rounding by truncation. The write happens when full=0, otherwise the FSM waits with addr held; no byte is ever dropped.
  - If addr < NCH-1: addr increments and the FSM returns to SETTLE.
  - Otherwise: the FSM goes to CSUM, or to DONE if the optional feature is absent.
- DONE (one cycle): frame_cnt increments and addr=0. Goes to HDR if cont_en=1; otherwise goes to IDLE with busy=0.
- cont_en falling mid-frame: the current frame completes, then the FSM returns to IDLE.
- FIFO write/read rules:
  - A write is accepted only when full=0.
  - rd_en with empty=1 is ignored.
  - q updates one cycle after an accepted rd_en.
  - A simultaneous read and write when not full is legal; the count is unchanged.
  - empty and full are registered and exact.
- Per-frame latency with no FIFO stall and samples arriving every P cycles: about NCH*(SETTLE_CYC + 2^AVG_LOG2*P + 2) + 3 cycles.

Optional Feature:
Macro SCAN_CSUM_EN.
- Defined: the CSUM state writes a trailer byte equal to the XOR of HDR_BYTE and all NCH data bytes of the frame, waiting on full like any other write. Frame length is NCH+2 bytes.
- Undefined: no CSUM state. Frame length is NCH+1 bytes and PUSH of the last channel goes directly to DONE.

Test Plan:
- Constant sample, NCH=4, SETTLE_CYC=8, AVG_LOG2=2, adc_data=12'hABC: one start pulse -> FIFO holds A5 AB AB AB AB, then A5 with SCAN_CSUM_EN; frame_cnt=1; busy drops; addr back to 0.
- Averaging: channel 0 samples 0x100, 0x101, 0x102, 0x103 -> sum 0x406, avg 0x101, byte 0x10.
- Settle discard: adc_valid with 0xFFF during SETTLE, then 0x200 x4 in ACC -> byte 0x20; no 0xFF byte appears.
- FIFO stall: FIFO_DEPTH=4, NCH=8, no reads -> full=1 and addr freezes with busy=1. Draining via rd_en resumes the scan; all 9 or 10 bytes are read in order with none lost.
- Continuous mode: cont_en=1 for 3 frames, then cleared mid-frame 4 -> frame_cnt=4, headers at the correct byte offsets, then IDLE.
- Reset mid-frame (addr=2): reset_n low for 1 cycle -> immediately addr=0, empty=1, busy=0, frame_cnt=0; a later start produces a clean frame.
